// File: rtl/sobol_seq.sv
// Sobol request sequencer: walks point indices and dimensions, dimension innermost,
// and issues one valid/ready request per accepted transfer to the downstream sobol stage.
module sobol_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned M     = 50,
   localparam int unsigned DW   = (M > 1) ? $clog2(M) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] n_paths_i,
   input  logic [WIDTH-1:0] idx_offset_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] idx_o,
   output logic [DW-1:0]    dim_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [DW-1:0] DIM_LAST = DW'(M - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [DW-1:0]    d_q, d_d;
   logic [WIDTH-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             xfer;
   logic             last_xfer;

   // Next-state: capture on start, advance counters per transfer, end on last or abort.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      p_d       = p_q;
      d_d       = d_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      xfer      = valid_q & ready_i;
      last_xfer = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               n_d = n_paths_i;
               p_d = '0;
               d_d = '0;
               if (n_paths_i != '0) begin
                  state_d = ST_RUN;
                  idx_d   = idx_offset_i;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (xfer) begin
               if (d_q == DIM_LAST) begin
                  d_d = '0;
                  if (p_q == n_q - WIDTH'(1)) begin
                     last_xfer = 1'b1;
                  end else begin
                     p_d   = p_q + WIDTH'(1);
                     // Index wraps modulo 2^WIDTH with no special handling.
                     idx_d = idx_q + WIDTH'(1);
                  end
               end else begin
                  d_d = d_q + DW'(1);
               end
            end
            // An abort coinciding with a transfer still lets that transfer count.
            if (abort_i || last_xfer) begin
               state_d = ST_DONE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; synchronous reset wins over start and abort.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         p_q     <= '0;
         d_q     <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         p_q     <= p_d;
         d_q     <= d_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign valid_o = valid_q;
   assign idx_o   = idx_q;
   assign dim_o   = d_q;

endmodule

// File: tb/tb_sobol_seq.sv
// Scoreboard bench for sobol_seq: stimulus pushes expected (idx, dim) pairs, a monitor pops
// them on every accepted transfer and also watches stalls, done pulses and busy.
module tb_sobol_seq;

   localparam int unsigned W   = 32;
   localparam int unsigned MA  = 4;
   localparam int unsigned DWA = 2;
   localparam int unsigned MB  = 2;
   localparam int unsigned DWB = 1;

   typedef struct packed {
      logic [W-1:0]   idx;
      logic [DWA-1:0] dim;
   } item_t;

   logic           clk = 1'b0;
   logic           rst, start, abort, ready;
   logic [W-1:0]   n_paths, idx_offset;
   logic           busy, done, valid;
   logic [W-1:0]   idx;
   logic [DWA-1:0] dim;

   logic           start2, ready2;
   logic [W-1:0]   n_paths2, idx_offset2;
   logic           busy2, done2, valid2;
   logic [W-1:0]   idx2;
   logic [DWB-1:0] dim2;

   int checks = 0;
   int errors = 0;
   item_t sb_q[$];

   int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cycles = 0;
   int xfer_cnt = 0, last_xfer_cyc = 0, valid_cnt = 0;
   bit rand_ready = 1'b0;
   bit prev_stall = 1'b0;
   logic [W-1:0]   prev_idx;
   logic [DWA-1:0] prev_dim;

   sobol_seq #(.WIDTH(W), .M(MA)) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .n_paths_i(n_paths),
      .idx_offset_i(idx_offset), .abort_i(abort), .busy_o(busy), .done_o(done),
      .valid_o(valid), .ready_i(ready), .idx_o(idx), .dim_o(dim)
   );

   sobol_seq #(.WIDTH(W), .M(MB)) u_dut_wrap (
      .clk_i(clk), .rst_i(rst), .start_i(start2), .n_paths_i(n_paths2),
      .idx_offset_i(idx_offset2), .abort_i(1'b0), .busy_o(busy2), .done_o(done2),
      .valid_o(valid2), .ready_i(ready2), .idx_o(idx2), .dim_o(dim2)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Downstream readiness: always ready, or ~70% ready when backpressure is enabled.
   always @(posedge clk) begin
      #1;
      ready = rand_ready ? ($urandom_range(0, 99) < 70) : 1'b1;
   end

   // Monitor: sampled mid-cycle, so values seen here are those the next rising edge uses.
   always @(negedge clk) begin
      item_t e;
      cyc++;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk(!busy, "done_with_busy", 64'(busy), 64'd0);
         end
         if (busy) busy_cycles++;
         if (valid) valid_cnt++;
         if (prev_stall) begin
            chk(valid && idx == prev_idx && dim == prev_dim, "stall_stable",
                {31'd0, valid, idx, dim}, {31'd1, prev_idx, prev_dim});
         end
         prev_stall = valid && !ready && !abort;
         prev_idx   = idx;
         prev_dim   = dim;
         if (valid && ready) begin
            xfer_cnt++;
            last_xfer_cyc = cyc;
            if (sb_q.size() == 0) begin
               chk(1'b0, "unexpected_xfer", {idx, 30'd0, dim}, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk(idx == e.idx && dim == e.dim, "xfer_data", {idx, 30'd0, dim},
                   {e.idx, 30'd0, e.dim});
            end
         end
      end
   end

   // Reference model: path-major, dimension-minor, index modulo 2^W.
   task automatic push_exp(input int n, input logic [W-1:0] off, input int limit);
      int cnt = 0;
      for (int p = 0; p < n; p++) begin
         for (int d = 0; d < int'(MA); d++) begin
            if (cnt < limit) sb_q.push_back('{idx: W'(off + W'(p)), dim: DWA'(d)});
            cnt++;
         end
      end
   endtask

   task automatic do_start(input logic [W-1:0] n, input logic [W-1:0] off);
      start = 1'b1; n_paths = n; idx_offset = off;
      @(posedge clk) #1;
      start = 1'b0;
      // Scrambled while running; the captured values must be the ones used.
      n_paths = $urandom; idx_offset = $urandom;
   endtask

   task automatic wait_done(input int c0, input string name);
      int i = 0;
      while (done_cnt == c0 && i < 300) begin
         @(posedge clk) #1;
         i++;
      end
      chk(done_cnt == c0 + 1, name, 64'(done_cnt - c0), 64'd1);
      repeat (3) @(posedge clk) #1;
      chk(done_cnt == c0 + 1, {name, "_single"}, 64'(done_cnt - c0), 64'd1);
      chk(sb_q.size() == 0, {name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
      chk(!busy && !valid, {name, "_idle"}, {62'd0, busy, valid}, 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk) #1;
   endtask

   initial begin
      int c0, x0, b0, v0, sc, n, i;
      logic [W-1:0] off;
      logic [W-1:0] exp_idx [4];
      rst = 1'b1; start = 1'b0; abort = 1'b0; n_paths = '0; idx_offset = '0;
      start2 = 1'b0; ready2 = 1'b1; n_paths2 = '0; idx_offset2 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk({valid, busy, done, idx, dim} == '0, "reset_state",
          {valid, busy, done, idx, dim}, 64'd0);

      // Basic sweep, always ready.
      idle(2);
      c0 = done_cnt; x0 = xfer_cnt; b0 = busy_cycles;
      push_exp(2, 5, 1000);
      do_start(2, 5);
      wait_done(c0, "basic_done");
      chk(xfer_cnt - x0 == 8, "basic_xfers", 64'(xfer_cnt - x0), 64'd8);
      chk(busy_cycles - b0 == 8, "basic_busy_cycles", 64'(busy_cycles - b0), 64'd8);
      chk(done_cyc == last_xfer_cyc + 1, "basic_done_latency",
          64'(done_cyc - last_xfer_cyc), 64'd1);

      // Backpressure, with a start pulsed mid-run that must be ignored.
      rand_ready = 1'b1;
      idle(2);
      c0 = done_cnt; x0 = xfer_cnt;
      push_exp(2, 5, 1000);
      do_start(2, 5);
      idle(2);
      start = 1'b1; n_paths = 5; idx_offset = 100;
      @(posedge clk) #1;
      start = 1'b0;
      wait_done(c0, "bp_done");
      idle(10);
      chk(xfer_cnt - x0 == 8, "bp_xfers", 64'(xfer_cnt - x0), 64'd8);
      chk(done_cnt == c0 + 1 && !busy, "bp_no_second_sweep", 64'(done_cnt - c0), 64'd1);

      // Empty sweep.
      c0 = done_cnt; v0 = valid_cnt;
      sc = cyc + 1;
      start = 1'b1; n_paths = 0; idx_offset = 9;
      @(posedge clk) #1;
      start = 1'b0;
      wait_done(c0, "empty_done");
      chk(done_cyc - sc >= 1 && done_cyc - sc <= 2, "empty_done_latency",
          64'(done_cyc - sc), 64'd2);
      chk(valid_cnt == v0, "empty_no_valid", 64'(valid_cnt - v0), 64'd0);

      // Random sweeps under backpressure.
      for (int k = 0; k < 4; k++) begin
         n = $urandom_range(1, 3);
         off = $urandom;
         c0 = done_cnt; x0 = xfer_cnt;
         push_exp(n, off, 1000);
         do_start(W'(n), off);
         wait_done(c0, "rand_done");
         chk(xfer_cnt - x0 == n * int'(MA), "rand_xfers", 64'(xfer_cnt - x0),
             64'(n * int'(MA)));
      end

      // Abort coinciding with the third transfer.
      rand_ready = 1'b0;
      idle(3);
      c0 = done_cnt; x0 = xfer_cnt;
      push_exp(2, 5, 3);
      do_start(2, 5);
      i = 0;
      while (!(valid && dim == 2) && i < 20) begin
         @(posedge clk) #1;
         i++;
      end
      abort = 1'b1;
      @(posedge clk) #1;
      abort = 1'b0;
      wait_done(c0, "abort_done");
      chk(xfer_cnt - x0 == 3, "abort_xfers", 64'(xfer_cnt - x0), 64'd3);

      // Abort while idle is ignored.
      c0 = done_cnt;
      abort = 1'b1;
      @(posedge clk) #1;
      abort = 1'b0;
      idle(3);
      chk(done_cnt == c0 && !busy, "abort_idle_ignored", 64'(done_cnt - c0), 64'd0);

      // Reset mid-sweep, coinciding with start and abort.
      c0 = done_cnt;
      push_exp(2, 5, 1000);
      do_start(2, 5);
      idle(2);
      rst = 1'b1; start = 1'b1; abort = 1'b1; n_paths = 3;
      @(posedge clk) #1;
      chk({valid, busy, done, idx, dim} == '0, "reset_mid_sweep",
          {valid, busy, done, idx, dim}, 64'd0);
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      sb_q.delete();
      idle(6);
      chk(done_cnt == c0 && !valid, "reset_no_done", 64'(done_cnt - c0), 64'd0);

      // Index wrap on the two-dimension instance.
      exp_idx[0] = '1; exp_idx[1] = '1; exp_idx[2] = '0; exp_idx[3] = '0;
      start2 = 1'b1; n_paths2 = 2; idx_offset2 = '1;
      @(posedge clk) #1;
      start2 = 1'b0;
      for (int j = 0; j < 4; j++) begin
         chk(valid2 && idx2 == exp_idx[j] && dim2 == DWB'(j % 2), "wrap_seq",
             {valid2, 30'd0, dim2, idx2}, {1'b1, 30'd0, DWB'(j % 2), exp_idx[j]});
         @(posedge clk) #1;
      end
      chk(done2 && !valid2 && !busy2, "wrap_done", {61'd0, done2, valid2, busy2}, 64'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
